// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-stage bundle: redirect, instruction-memory request/response and decode slot.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; valid never waits on ready.
interface fetch_prefetch_queue_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 16
);
   logic               redirect;
   logic [PC_W-1:0]    redirect_tgt;
   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [PC_W-1:0]    imem_req_addr;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;

   modport master (
      input  redirect, redirect_tgt, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
      output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
   );

   modport slave (
      output redirect, redirect_tgt, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
      input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential-PC fetch with a DEPTH-entry prefetch queue, credit-limited requests and redirect squashing.
// Optional FETCH_BYPASS_EN: a live response is forwarded to decode in the same cycle when the queue is empty.
module fetch_prefetch_queue #(
   parameter int              PC_W     = 16,
   parameter int              INSTR_W  = 16,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   fetch_prefetch_queue_if.master     io_bus,
   output logic [$clog2(DEPTH):0]     o_dbg_inflight,
   output logic [$clog2(DEPTH):0]     o_dbg_discard,
   output logic [$clog2(DEPTH):0]     o_dbg_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [PC_W-1:0]    r_q_pc    [DEPTH];
   logic [INSTR_W-1:0] r_q_instr [DEPTH];
   logic [AW-1:0]      r_rd_ptr;
   logic [AW-1:0]      r_wr_ptr;
   logic [CW-1:0]      r_count;
   logic [CW-1:0]      r_inflight;
   logic [CW-1:0]      r_discard;
   logic [PC_W-1:0]    r_fetch_pc;
   logic [PC_W-1:0]    r_rsp_pc;

   logic               w_empty;
   logic               w_rsp_fire;
   logic               w_live_rsp;
   logic [CW:0]        w_credits_used;
   logic               w_req_valid;
   logic               w_req_fire;
   logic               w_bypass;
   logic               w_out_valid;
   logic               w_pop;
   logic               w_q_pop;
   logic               w_push;

   assign w_empty        = (r_count == '0);
   // A response with nothing outstanding is a protocol error and is dropped silently.
   assign w_rsp_fire     = io_bus.imem_rsp_valid && (r_inflight != '0);
   assign w_live_rsp     = w_rsp_fire && (r_discard == '0) && !io_bus.redirect;
   assign w_credits_used = {1'b0, r_count} + {1'b0, r_inflight};
   assign w_req_valid    = rst_n && !io_bus.redirect && (w_credits_used < DEPTH_C);
   assign w_req_fire     = w_req_valid && io_bus.imem_req_ready;

`ifdef FETCH_BYPASS_EN
   assign w_bypass = w_empty && w_live_rsp;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_out_valid = !w_empty || w_bypass;
   assign w_pop       = w_out_valid && io_bus.out_ready;
   assign w_q_pop     = w_pop && !w_empty;
   assign w_push      = w_live_rsp && !(w_bypass && io_bus.out_ready);

   assign io_bus.imem_req_valid = w_req_valid;
   assign io_bus.imem_req_addr  = r_fetch_pc;
   assign io_bus.out_valid      = w_out_valid;
   assign io_bus.out_pc         = w_bypass ? r_rsp_pc : r_q_pc[r_rd_ptr];
   assign io_bus.out_instr      = w_bypass ? io_bus.imem_rsp_data : r_q_instr[r_rd_ptr];

   assign o_dbg_inflight = r_inflight;
   assign o_dbg_discard  = r_discard;
   assign o_dbg_count    = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_discard  <= '0;
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
      end else if (io_bus.redirect) begin
         // Every request still outstanding after this edge belongs to the old path.
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_fetch_pc <= io_bus.redirect_tgt;
         r_rsp_pc   <= io_bus.redirect_tgt;
         r_inflight <= r_inflight - CW'(w_rsp_fire);
         r_discard  <= r_inflight - CW'(w_rsp_fire);
      end else begin
         if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + PC_W'(1);
         end
         r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_fire);
         if (w_rsp_fire && (r_discard != '0)) begin
            r_discard <= r_discard - CW'(1);
         end
         // rsp_pc tracks live responses, including ones handed straight to decode.
         if (w_live_rsp) begin
            r_rsp_pc <= r_rsp_pc + PC_W'(1);
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_q_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_q_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_wr_ptr]    <= r_rsp_pc;
         r_q_instr[r_wr_ptr] <= io_bus.imem_rsp_data;
      end
   end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: startup vector table, redirect/wrap/reset sequences, randomized run vs a transaction model.
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;
   localparam int PC_W    = 16;
   localparam int INSTR_W = 16;
   localparam int DEPTH   = 4;
   localparam int CW      = $clog2(DEPTH) + 1;
   localparam int EW      = PC_W + INSTR_W;

   logic clk = 1'b0;
   logic rst_n;
   logic [CW-1:0] dbg_inflight, dbg_discard, dbg_count;

   always #5 clk = ~clk;

   fetch_prefetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   fetch_prefetch_queue #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(16'h0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .io_bus         (bus),
      .o_dbg_inflight (dbg_inflight),
      .o_dbg_discard  (dbg_discard),
      .o_dbg_count    (dbg_count)
   );

   // Memory requests in flight, tagged with the fetch path (epoch) that issued them.
   typedef struct {
      logic [PC_W-1:0] addr;
      int              epoch;
      int              due;
   } req_t;

   typedef struct {
      logic            ordy;
      logic            ov;
      logic [PC_W-1:0] pc;
      logic            rv;
      logic [PC_W-1:0] addr;
   } vec_t;

   req_t            pend_q[$];
   logic [EW-1:0]   exp_q[$];
   vec_t            tbl[15];

   int              checks = 0;
   int              errors = 0;
   int              cyc = 0;
   int              lat = 1;
   int              m_epoch = 0;
   logic [PC_W-1:0] m_fetch_pc = '0;

   logic            c_redir, c_ordy, c_mrdy, c_rsp;
   logic [PC_W-1:0] c_tgt;
   logic            e_rv, e_ov, e_byp;
   logic            s_ov;
   logic [PC_W-1:0] s_pc;
   logic [INSTR_W-1:0] s_instr;

   function automatic logic [INSTR_W-1:0] memf(input logic [PC_W-1:0] a);
      logic [15:0] t;
      t = a * 16'h9E37;
      return t ^ 16'h5A5A;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input logic redir, input logic [PC_W-1:0] tgt, input logic ordy, input logic mrdy);
      c_redir = redir;
      c_tgt   = tgt;
      c_ordy  = ordy;
      c_mrdy  = mrdy;
      c_rsp   = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
      bus.redirect       = redir;
      bus.redirect_tgt   = tgt;
      bus.out_ready      = ordy;
      bus.imem_req_ready = mrdy;
      bus.imem_rsp_valid = c_rsp;
      bus.imem_rsp_data  = c_rsp ? memf(pend_q[0].addr) : INSTR_W'($urandom);
   endtask

   task automatic check_cycle();
      int stale;
      logic [EW-1:0] head;
      stale = 0;
      foreach (pend_q[i]) if (pend_q[i].epoch != m_epoch) stale++;
      e_rv  = !c_redir && ((exp_q.size() + pend_q.size()) < DEPTH);
      e_byp = 1'b0;
`ifdef FETCH_BYPASS_EN
      e_byp = (exp_q.size() == 0) && c_rsp && !c_redir && (pend_q[0].epoch == m_epoch);
`endif
      e_ov  = (exp_q.size() > 0) || e_byp;
      s_ov    = bus.out_valid;
      s_pc    = bus.out_pc;
      s_instr = bus.out_instr;
      check("req_valid", 32'(bus.imem_req_valid), 32'(e_rv));
      check("req_addr", 32'(bus.imem_req_addr), 32'(m_fetch_pc));
      check("out_valid", 32'(bus.out_valid), 32'(e_ov));
      if (e_ov) begin
         head = (exp_q.size() > 0) ? exp_q[0] : {pend_q[0].addr, memf(pend_q[0].addr)};
         check("out_pc", 32'(bus.out_pc), 32'(head[EW-1:INSTR_W]));
         check("out_instr", 32'(bus.out_instr), 32'(head[INSTR_W-1:0]));
      end
      check("inflight", 32'(dbg_inflight), 32'(pend_q.size()));
      check("discard", 32'(dbg_discard), 32'(stale));
   endtask

   task automatic update();
      req_t p;
      logic byp_take;
      byp_take = e_byp && c_ordy;
      p = '{addr: '0, epoch: -1, due: 0};
      if (c_rsp) p = pend_q.pop_front();
      if (c_redir) begin
         exp_q.delete();
         m_fetch_pc = c_tgt;
         m_epoch++;
      end else begin
         if (e_ov && c_ordy && (exp_q.size() > 0)) void'(exp_q.pop_front());
         if (c_rsp && (p.epoch == m_epoch) && !byp_take) exp_q.push_back({p.addr, memf(p.addr)});
         if (e_rv && c_mrdy) begin
            pend_q.push_back('{addr: m_fetch_pc, epoch: m_epoch, due: cyc + lat});
            m_fetch_pc = m_fetch_pc + 16'd1;
         end
      end
      cyc++;
   endtask

   task automatic step(input logic redir, input logic [PC_W-1:0] tgt, input logic ordy, input logic mrdy);
      drive(redir, tgt, ordy, mrdy);
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      update();
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PC_W-1:0] got[4];
      logic [PC_W-1:0] wrap_exp[4];
      int n;
      int budget;

      // ordy, out_valid, out_pc, req_valid, req_addr -- 1-cycle memory, always ready
      tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
      tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
      tbl[2]  = '{1'b1, 1'b1, 16'h0000, 1'b1, 16'h0002};
      tbl[3]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 16'h0003};
      tbl[4]  = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0004};
      tbl[5]  = '{1'b1, 1'b1, 16'h0003, 1'b1, 16'h0005};
      tbl[6]  = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0006};
      tbl[7]  = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0007};
      tbl[8]  = '{1'b0, 1'b1, 16'h0004, 1'b0, 16'h0008};
      tbl[9]  = '{1'b0, 1'b1, 16'h0004, 1'b0, 16'h0008};
      tbl[10] = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'h0008};
      tbl[11] = '{1'b1, 1'b1, 16'h0005, 1'b1, 16'h0008};
      tbl[12] = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0009};
      tbl[13] = '{1'b1, 1'b1, 16'h0007, 1'b1, 16'h000A};
      tbl[14] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h000B};
      wrap_exp[0] = 16'hFFFE;
      wrap_exp[1] = 16'hFFFF;
      wrap_exp[2] = 16'h0000;
      wrap_exp[3] = 16'h0001;

      // reset
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_inflight", 32'(dbg_inflight), 32'd0);
      check("rst_discard", 32'(dbg_discard), 32'd0);
      check("rst_count", 32'(dbg_count), 32'd0);
      rst_n = 1'b1;

      // startup streaming and a four-cycle decode stall
      for (int i = 0; i < 15; i++) begin
         drive(1'b0, '0, tbl[i].ordy, 1'b1);
         @(negedge clk);
         check_cycle();
`ifndef FETCH_BYPASS_EN
         check("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[i].ov));
         if (tbl[i].ov) check("tbl_out_pc", 32'(bus.out_pc), 32'(tbl[i].pc));
         if (tbl[i].ov) check("tbl_out_instr", 32'(bus.out_instr), 32'(memf(tbl[i].pc)));
         check("tbl_req_valid", 32'(bus.imem_req_valid), 32'(tbl[i].rv));
         check("tbl_req_addr", 32'(bus.imem_req_addr), 32'(tbl[i].addr));
`endif
         @(posedge clk);
         update();
         #1;
      end

      // drain, then three requests in flight on a slow memory and a redirect to 0x0040
      budget = 0;
      while ((pend_q.size() > 0 || exp_q.size() > 0) && budget < 30) begin
         step(1'b0, '0, 1'b1, 1'b0);
         budget++;
      end
      lat = 4;
      repeat (3) step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 16'h0040, 1'b1, 1'b1);
      check("redir_discard3", 32'(dbg_discard), 32'd3);
      budget = 0;
      s_ov = 1'b0;
      while (!s_ov && budget < 30) begin
         step(1'b0, '0, 1'b1, 1'b1);
         budget++;
      end
      check("redir40_valid", 32'(s_ov), 32'd1);
      check("redir40_pc", 32'(s_pc), 32'h0040);
      check("redir40_instr", 32'(s_instr), 32'(memf(16'h0040)));

      // redirect together with a response and a pop, then a second redirect to 0x0100
      lat = 1;
      budget = 0;
      while (!((exp_q.size() > 0) && (pend_q.size() > 0) && (pend_q[0].due <= cyc)) && budget < 30) begin
         step(1'b0, '0, 1'b1, 1'b1);
         budget++;
      end
      check("b2b_setup", 32'((exp_q.size() > 0) && (pend_q.size() > 0)), 32'd1);
      step(1'b1, 16'h0200, 1'b1, 1'b1);
      step(1'b1, 16'h0100, 1'b1, 1'b1);
      budget = 0;
      s_ov = 1'b0;
      while (!s_ov && budget < 30) begin
         step(1'b0, '0, 1'b1, 1'b1);
         budget++;
      end
      check("b2b_first_pc", 32'(s_pc), 32'h0100);
      repeat (3) begin
         step(1'b0, '0, 1'b1, 1'b1);
         if (s_ov) check("b2b_stream_hi", 32'(s_pc[15:8]), 32'h01);
      end
      repeat (8) step(1'b0, '0, 1'b1, 1'b0);
      check("idle_inflight", 32'(dbg_inflight), 32'd0);
      check("idle_discard", 32'(dbg_discard), 32'd0);

      // PC wrap across 0xFFFF
      step(1'b1, 16'hFFFE, 1'b1, 1'b1);
      n = 0;
      budget = 0;
      while (n < 4 && budget < 30) begin
         step(1'b0, '0, 1'b1, 1'b1);
         if (s_ov) begin
            got[n] = s_pc;
            n++;
         end
         budget++;
      end
      check("wrap_count", 32'(n), 32'd4);
      for (int i = 0; i < 4; i++) check("wrap_pc", 32'(got[i]), 32'(wrap_exp[i]));

      // asynchronous reset with requests in flight
      lat = 3;
      budget = 0;
      while (pend_q.size() < 2 && budget < 20) begin
         step(1'b0, '0, 1'b0, 1'b1);
         budget++;
      end
      drive(1'b0, '0, 1'b0, 1'b1);
      #2;
      check("async_pre_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
      rst_n = 1'b0;
      #1;
      check("async_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("async_inflight", 32'(dbg_inflight), 32'd0);
      check("async_count", 32'(dbg_count), 32'd0);
      exp_q.delete();
      pend_q.delete();
      m_fetch_pc = 16'h0000;
      drive(1'b0, '0, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, '0, 1'b1, 1'b1);
      @(negedge clk);
      check_cycle();
      check("restart_addr", 32'(bus.imem_req_addr), 32'h0000);
      check("restart_inflight", 32'(dbg_inflight), 32'd0);
      @(posedge clk);
      update();
      #1;

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic            r;
         logic [PC_W-1:0] t;
         if (i % 50 == 0) lat = $urandom_range(1, 4);
         r = ($urandom_range(0, 99) < 4);
         t = ($urandom_range(0, 3) == 0) ? PC_W'($urandom_range(16'hFFFC, 16'hFFFF)) : PC_W'($urandom);
         step(r, t, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 80);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
